// File: rtl/pwl_filter_reset_seq.sv
// Reset/settle sequencer for a PWL linear filter: holds the filter in reset,
// steps its reset-path pole fast->slow, settles, then releases into RUN.
module pwl_filter_reset_seq #(
    parameter real         FP_RST_FAST   = 1.0e9,
    parameter real         FP_RST_SLOW   = 1.0e8,
    parameter int unsigned HOLD_FAST_CYC = 4,
    parameter int unsigned HOLD_SLOW_CYC = 8,
    parameter int unsigned SETTLE_CYC    = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic cfg_complex,
    output logic filt_reset,
    output real  fp_rst,
    output logic en_complex,
    output logic busy,
    output logic ready,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HF,
        S_HS,
        S_ST,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               filt_reset_q;
    logic               en_complex_q;
    logic               busy_q;
    logic               ready_q;
    logic               done_q;
    real                fp_q;

    // Resolve zero-length phases so entry lands on the first real phase.
    function automatic state_t land(input state_t s);
        state_t r;
        r = s;
        if (r == S_HF && HOLD_FAST_CYC == 0) r = S_HS;
        if (r == S_HS && HOLD_SLOW_CYC == 0) r = S_ST;
        if (r == S_ST && SETTLE_CYC == 0)    r = S_RUN;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] load(input state_t s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            S_HF:    v = CNT_W'(HOLD_FAST_CYC - 1);
            S_HS:    v = CNT_W'(HOLD_SLOW_CYC - 1);
            S_ST:    v = CNT_W'(SETTLE_CYC - 1);
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = land(S_HF);
            cnt_d   = load(state_d);
        end else begin
            case (state_q)
                S_HF: begin
                    if (cnt_q == '0) begin
                        state_d = land(S_HS);
                        cnt_d   = load(state_d);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HS: begin
                    if (cnt_q == '0) begin
                        state_d = land(S_ST);
                        cnt_d   = load(state_d);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ST: begin
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                    cnt_d   = cnt_q;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered Moore values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            filt_reset_q <= 1'b0;
            en_complex_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            fp_q         <= FP_RST_FAST;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            filt_reset_q <= (state_d == S_HF) || (state_d == S_HS);
            busy_q       <= (state_d == S_HF) || (state_d == S_HS)
                            || (state_d == S_ST);
            ready_q      <= (state_d == S_RUN);
            done_q       <= (state_d == S_RUN)
                            && ((state_q != S_RUN) || start);
            if (start) begin
                en_complex_q <= cfg_complex;
            end
            if (state_d == S_HF) begin
                fp_q <= FP_RST_FAST;
            end else if (state_d == S_HS) begin
                fp_q <= FP_RST_SLOW;
            end
        end
    end

    assign filt_reset = filt_reset_q;
    assign fp_rst     = fp_q;
    assign en_complex = en_complex_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwl_filter_reset_seq.sv
// Bench for pwl_filter_reset_seq: three phase-length configurations driven
// by shared directed + random stimulus, checked against a timeline model.
module tb_pwl_filter_reset_seq;

    localparam real FAST = 1.0e9;
    localparam real SLOW = 1.0e8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic cfg = 1'b0;

    logic [2:0] fr, en, bz, rd, dn;
    real fp0, fp1, fp2;

    int errors = 0;
    int checks = 0;

    int F[3] = '{4, 4, 0};
    int S[3] = '{8, 0, 0};
    int T[3] = '{16, 0, 0};

    bit  started[3];
    int  t[3];
    bit  men[3];
    real mfp[3];
    real mprev[3];

    always #5 clk = ~clk;

    pwl_filter_reset_seq #(
        .FP_RST_FAST(FAST), .FP_RST_SLOW(SLOW),
        .HOLD_FAST_CYC(4), .HOLD_SLOW_CYC(8), .SETTLE_CYC(16), .CNT_W(8)
    ) u0 (
        .clk(clk), .rstn(rstn), .start(start), .cfg_complex(cfg),
        .filt_reset(fr[0]), .fp_rst(fp0), .en_complex(en[0]),
        .busy(bz[0]), .ready(rd[0]), .done(dn[0])
    );

    pwl_filter_reset_seq #(
        .FP_RST_FAST(FAST), .FP_RST_SLOW(SLOW),
        .HOLD_FAST_CYC(4), .HOLD_SLOW_CYC(0), .SETTLE_CYC(0), .CNT_W(8)
    ) u1 (
        .clk(clk), .rstn(rstn), .start(start), .cfg_complex(cfg),
        .filt_reset(fr[1]), .fp_rst(fp1), .en_complex(en[1]),
        .busy(bz[1]), .ready(rd[1]), .done(dn[1])
    );

    pwl_filter_reset_seq #(
        .FP_RST_FAST(FAST), .FP_RST_SLOW(SLOW),
        .HOLD_FAST_CYC(0), .HOLD_SLOW_CYC(0), .SETTLE_CYC(0), .CNT_W(8)
    ) u2 (
        .clk(clk), .rstn(rstn), .start(start), .cfg_complex(cfg),
        .filt_reset(fr[2]), .fp_rst(fp2), .en_complex(en[2]),
        .busy(bz[2]), .ready(rd[2]), .done(dn[2])
    );

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            started[i] = 1'b0;
            t[i]       = 0;
            men[i]     = 1'b0;
            mfp[i]     = FAST;
            mprev[i]   = FAST;
        end
    endtask

    // t = clocks elapsed since the last accepted start (t=0 at that edge).
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (start) begin
                mprev[i]   = mfp[i];
                started[i] = 1'b1;
                t[i]       = 0;
                men[i]     = cfg;
            end else if (started[i] && t[i] < 1000) begin
                t[i]++;
            end
            if (started[i]) begin
                if (S[i] > 0 && t[i] >= F[i]) mfp[i] = SLOW;
                else if (F[i] > 0)            mfp[i] = FAST;
                else                          mfp[i] = mprev[i];
            end
        end
    endtask

    task automatic chk(input logic obs, input logic exp,
                       input string tag, input int i);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] t=%0d got=%b exp=%b", tag, i, t[i], obs, exp);
        end
    endtask

    task automatic chkr(input real obs, input real exp, input int i);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL fp_rst[%0d] t=%0d got=%g exp=%g", i, t[i], obs, exp);
        end
    endtask

    task automatic chki(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        real fpv[3];
        int  tot;
        fpv[0] = fp0;
        fpv[1] = fp1;
        fpv[2] = fp2;
        for (int i = 0; i < 3; i++) begin
            tot = F[i] + S[i] + T[i];
            chk(fr[i], started[i] && t[i] < F[i] + S[i], "filt_reset", i);
            chk(bz[i], started[i] && t[i] < tot, "busy", i);
            chk(rd[i], started[i] && t[i] >= tot, "ready", i);
            chk(dn[i], started[i] && t[i] == tot, "done", i);
            chk(en[i], men[i], "en_complex", i);
            chkr(fpv[i], mfp[i], i);
        end
    endtask

    task automatic step(input logic s, input logic c);
        start = s;
        cfg   = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int n;
    int dcnt;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rstn = 1'b1;
        repeat (8) step(1'b0, 1'b0);

        // Full sequence with complex mode; cfg toggles must not leak through.
        step(1'b1, 1'b1);
        n = 0;
        dcnt = 0;
        while (!rd[0] && n < 60) begin
            step(1'b0, 1'($urandom % 2));
            n++;
            dcnt += int'(dn[0]);
        end
        chki(n, 28, "latency_default");
        step(1'b0, 1'b0);
        dcnt += int'(dn[0]);
        chki(dcnt, 1, "done_count_first");

        // Second start from RUN with cfg=0 replays the full sequence.
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b1);

        // Restart on the 5th SETTLE cycle.
        step(1'b1, 1'b1);
        dcnt = 0;
        repeat (16) begin
            step(1'b0, 1'b0);
            dcnt += int'(dn[0]);
        end
        step(1'b1, 1'b0);
        n = 0;
        while (!rd[0] && n < 60) begin
            step(1'b0, 1'b1);
            n++;
            dcnt += int'(dn[0]);
        end
        chki(n, 28, "latency_restart");
        repeat (3) begin
            step(1'b0, 1'b0);
            dcnt += int'(dn[0]);
        end
        chki(dcnt, 1, "done_count_restart");

        // Start held high.
        repeat (10) step(1'b1, 1'($urandom % 2));
        step(1'b0, 1'b0);

        // Async reset during HOLD_SLOW, then stay idle.
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        do_reset();
        repeat (5) step(1'b0, 1'b1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(1'($urandom_range(0, 9) == 0), 1'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
